// File: rtl/avalon_reg_pkg.sv
// Shared types and bit positions for the Avalon-MM register bank.
// Imported by the bank top and by anything that decodes CTRL/STAT.
package avalon_reg_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int CTRL_START_BIT = 0;
  localparam int CTRL_IE_BIT    = 1;

  localparam int STAT_DONE_BIT  = 0;
  localparam int STAT_BUSY_BIT  = 1;
  localparam int STAT_ERR_BIT   = 2;

endpackage

// File: rtl/byte_en_register.sv
// DATA_W-wide register with async active-low clear, per-byte host writes
// and a full-width load port; a load takes priority over byte writes.
module byte_en_register #(
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DATA_W/8-1:0] byte_en,
  input  logic [DATA_W-1:0]   wdata,
  input  logic                load,
  input  logic [DATA_W-1:0]   load_data,
  output logic [DATA_W-1:0]   q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= load_data;
    end else begin
      for (int b = 0; b < DATA_W/8; b++) begin
        if (byte_en[b]) q[b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/avalon_reg_bank.sv
// Avalon-MM slave register bank in front of a start/done compute core:
// operand registers, latched result registers, CTRL/STAT and an interrupt.
module avalon_reg_bank
  import avalon_reg_pkg::*;
#(
  parameter  int DATA_W   = 32,
  parameter  int NUM_REGS = 16,
  parameter  int RO_BASE  = 8,
  parameter  int RO_COUNT = 4,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       avl_read,
  input  logic                       avl_write,
  input  logic                       avl_cs,
  input  logic [DATA_W/8-1:0]        avl_byte_en,
  input  logic [ADDR_W-1:0]          avl_addr,
  input  logic [DATA_W-1:0]          avl_writedata,
  output logic [DATA_W-1:0]          avl_readdata,
  output logic                       avl_readdatavalid,
  output logic [RO_BASE*DATA_W-1:0]  core_operands,
  output logic                       core_start,
  input  logic                       core_done,
  input  logic [RO_COUNT*DATA_W-1:0] core_result,
  output logic                       irq,
  output logic [DATA_W-1:0]          export_data
);

  localparam int NB = DATA_W/8;
  localparam logic [ADDR_W-1:0] CTRL_ADDR = ADDR_W'(NUM_REGS-2);
  localparam logic [ADDR_W-1:0] STAT_ADDR = ADDR_W'(NUM_REGS-1);

  state_t state;
  logic ctrl_ie, stat_done, stat_err;

  logic [DATA_W-1:0] op_q  [RO_BASE];
  logic [NB-1:0]     op_be [RO_BASE];
  logic [DATA_W-1:0] res_q [RO_COUNT];

  logic wr_acc, rd_acc, op_wr, op_wr_ok, ctrl_wr, stat_wr;
  logic start_wr, done_w1c, err_w1c, done_evt, res_load, err_set;
  logic [DATA_W-1:0] rd_val;

  assign wr_acc   = avl_cs & avl_write;
  assign rd_acc   = avl_cs & avl_read;
  assign op_wr    = wr_acc && (int'(avl_addr) < RO_BASE);
  assign op_wr_ok = op_wr && (state != RUN);
  assign ctrl_wr  = wr_acc && (avl_addr == CTRL_ADDR) && avl_byte_en[0];
  assign stat_wr  = wr_acc && (avl_addr == STAT_ADDR) && avl_byte_en[0];
  assign start_wr = ctrl_wr && avl_writedata[CTRL_START_BIT];
  assign done_w1c = stat_wr && avl_writedata[STAT_DONE_BIT];
  assign err_w1c  = stat_wr && avl_writedata[STAT_ERR_BIT];
  assign done_evt = core_done && (state == RUN);
  assign res_load = done_evt;

  // Overrun start, operand write while the core is using operands, or a stray done.
  assign err_set = (start_wr && (state == RUN)) ||
                   (op_wr && (state == RUN)) ||
                   (core_done && (state != RUN));

  for (genvar i = 0; i < RO_BASE; i++) begin : g_op
    assign op_be[i] = (op_wr_ok && (avl_addr == ADDR_W'(i))) ? avl_byte_en : '0;

    byte_en_register #(.DATA_W(DATA_W)) u_op_reg (
      .clk      (clk),
      .rst_n    (reset_n),
      .byte_en  (op_be[i]),
      .wdata    (avl_writedata),
      .load     (1'b0),
      .load_data('0),
      .q        (op_q[i])
    );

    assign core_operands[i*DATA_W +: DATA_W] = op_q[i];
  end

  for (genvar j = 0; j < RO_COUNT; j++) begin : g_res
    byte_en_register #(.DATA_W(DATA_W)) u_res_reg (
      .clk      (clk),
      .rst_n    (reset_n),
      .byte_en  ('0),
      .wdata    ('0),
      .load     (res_load),
      .load_data(core_result[j*DATA_W +: DATA_W]),
      .q        (res_q[j])
    );
  end

  assign export_data = {op_q[0][DATA_W-1:DATA_W/2], op_q[RO_BASE-1][DATA_W/2-1:0]};

  always_comb begin
    rd_val = '0;
    for (int i = 0; i < RO_BASE; i++) begin
      if (avl_addr == ADDR_W'(i)) rd_val = op_q[i];
    end
    for (int j = 0; j < RO_COUNT; j++) begin
      if (avl_addr == ADDR_W'(RO_BASE + j)) rd_val = res_q[j];
    end
    if (avl_addr == CTRL_ADDR) begin
      rd_val[CTRL_IE_BIT] = ctrl_ie;
    end
    if (avl_addr == STAT_ADDR) begin
      rd_val[STAT_DONE_BIT] = stat_done;
      rd_val[STAT_BUSY_BIT] = (state == RUN);
      rd_val[STAT_ERR_BIT]  = stat_err;
    end
  end

  // Read data is sampled before this edge's write lands, so read+write returns the old value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      avl_readdata      <= '0;
      avl_readdatavalid <= 1'b0;
    end else begin
      avl_readdatavalid <= rd_acc;
      if (rd_acc) avl_readdata <= rd_val;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      core_start <= 1'b0;
      ctrl_ie    <= 1'b0;
      stat_done  <= 1'b0;
      stat_err   <= 1'b0;
      irq        <= 1'b0;
    end else begin
      core_start <= 1'b0;
      irq        <= stat_done & ctrl_ie;
      if (ctrl_wr) ctrl_ie <= avl_writedata[CTRL_IE_BIT];
      if (err_set) stat_err <= 1'b1;
      else if (err_w1c) stat_err <= 1'b0;

      case (state)
        IDLE: begin
          if (start_wr) begin
            state      <= RUN;
            core_start <= 1'b1;
          end
        end
        RUN: begin
          // A completing core beats both a done clear and an overrun start.
          if (done_evt) begin
            state     <= DONE;
            stat_done <= 1'b1;
          end
        end
        DONE: begin
          if (start_wr) begin
            state      <= RUN;
            core_start <= 1'b1;
            stat_done  <= 1'b0;
          end else if (done_w1c) begin
            state     <= IDLE;
            stat_done <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_avalon_reg_bank.sv
// Scoreboard bench for avalon_reg_bank: expected read data is queued when a
// read is issued and compared when AVL_READDATAVALID returns it.
module tb_avalon_reg_bank;

  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 16;
  localparam int RO_BASE  = 8;
  localparam int RO_COUNT = 4;
  localparam int ADDR_W   = 4;
  localparam logic [3:0] CTRL = 4'd14;
  localparam logic [3:0] STAT = 4'd15;

  logic clk;
  logic resetN;
  logic avlRead, avlWrite, avlCs;
  logic [3:0] avlByteEn;
  logic [ADDR_W-1:0] avlAddr;
  logic [DATA_W-1:0] avlWritedata;
  logic [DATA_W-1:0] avlReaddata;
  logic avlReaddatavalid;
  logic [RO_BASE*DATA_W-1:0] coreOperands;
  logic coreStart;
  logic coreDone;
  logic [RO_COUNT*DATA_W-1:0] coreResult;
  logic irq;
  logic [DATA_W-1:0] exportData;

  int compareCount  = 0;
  int mismatchCount = 0;
  int startCount    = 0;
  logic [31:0] expQ[$];

  avalon_reg_bank #(
    .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .RO_BASE(RO_BASE), .RO_COUNT(RO_COUNT)
  ) dut (
    .clk              (clk),
    .reset_n          (resetN),
    .avl_read         (avlRead),
    .avl_write        (avlWrite),
    .avl_cs           (avlCs),
    .avl_byte_en      (avlByteEn),
    .avl_addr         (avlAddr),
    .avl_writedata    (avlWritedata),
    .avl_readdata     (avlReaddata),
    .avl_readdatavalid(avlReaddatavalid),
    .core_operands    (coreOperands),
    .core_start       (coreStart),
    .core_done        (coreDone),
    .core_result      (coreResult),
    .irq              (irq),
    .export_data      (exportData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every comparison in the bench funnels through here.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Drives one bus/core cycle starting at a falling edge; returns just after the accepting edge.
  task automatic applyStimulus(input bit rd, input bit wr, input logic [3:0] addr,
                               input logic [31:0] data, input logic [3:0] be,
                               input bit done, input logic [31:0] expRd);
    @(negedge clk);
    avlCs        = rd | wr;
    avlRead      = rd;
    avlWrite     = wr;
    avlAddr      = addr;
    avlWritedata = data;
    avlByteEn    = be;
    coreDone     = done;
    if (rd) expQ.push_back(expRd);
    @(posedge clk);
    #1;
    avlCs     = 1'b0;
    avlRead   = 1'b0;
    avlWrite  = 1'b0;
    avlByteEn = 4'h0;
    coreDone  = 1'b0;
  endtask

  task automatic busWrite(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] be);
    applyStimulus(1'b0, 1'b1, addr, data, be, 1'b0, 32'h0);
  endtask

  task automatic busRead(input logic [3:0] addr, input logic [31:0] expRd);
    applyStimulus(1'b1, 1'b0, addr, 32'h0, 4'h0, 1'b0, expRd);
    @(negedge clk);
    checkOutput("rdv_latency", {31'b0, avlReaddatavalid}, 32'h1);
  endtask

  task automatic waitCycles(input int n);
    for (int k = 0; k < n; k++) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (resetN && avlReaddatavalid === 1'b1) begin
      if (expQ.size() == 0) checkOutput("unexpected_rdv", 32'h1, 32'h0);
      else checkOutput("read_data", avlReaddata, expQ.pop_front());
    end
  end

  always @(negedge clk) begin
    if (coreStart === 1'b1) startCount++;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    resetN = 1'b1; avlRead = 0; avlWrite = 0; avlCs = 0; avlByteEn = 0;
    avlAddr = 0; avlWritedata = 0; coreDone = 0; coreResult = '0;
    #1 resetN = 1'b0;
    #2;
    checkOutput("rst_readdata", avlReaddata, 32'h0);
    checkOutput("rst_rdv", {31'b0, avlReaddatavalid}, 32'h0);
    checkOutput("rst_start", {31'b0, coreStart}, 32'h0);
    checkOutput("rst_irq", {31'b0, irq}, 32'h0);
    checkOutput("rst_export", exportData, 32'h0);
    checkOutput("rst_operands", {31'b0, |coreOperands}, 32'h0);
    @(negedge clk); @(negedge clk);
    resetN = 1'b1;

    // Byte-lane masked operand write and export composition
    busWrite(4'd0, 32'hDEADBEEF, 4'b0101);
    busRead(4'd0, 32'h00AD00EF);
    checkOutput("operands_w0", coreOperands[31:0], 32'h00AD00EF);
    checkOutput("export_a", exportData, 32'h00AD0000);
    busWrite(4'd7, 32'h11223344, 4'hF);
    checkOutput("export_b", exportData, 32'h00AD3344);

    // Back-to-back reads
    @(negedge clk);
    avlCs = 1; avlRead = 1; avlAddr = 4'd0; expQ.push_back(32'h00AD00EF);
    @(negedge clk);
    avlAddr = 4'd7; expQ.push_back(32'h11223344);
    @(negedge clk);
    avlCs = 0; avlRead = 0;

    // CTRL write without lane 0 is ignored
    busWrite(CTRL, 32'h3, 4'b0010);
    busRead(CTRL, 32'h0);
    checkOutput("no_start_lane", startCount, 0);

    // Start, then complete with results
    coreResult = {32'h44444444, 32'h33333333, 32'hABCD0002, 32'h12345678};
    busWrite(CTRL, 32'h3, 4'hF);
    checkOutput("start_pulse_hi", {31'b0, coreStart}, 32'h1);
    waitCycles(1);
    checkOutput("start_pulse_lo", {31'b0, coreStart}, 32'h0);
    busRead(STAT, 32'h2);
    busRead(CTRL, 32'h2);
    checkOutput("start_count1", startCount, 1);
    applyStimulus(1'b0, 1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 32'h0);
    waitCycles(1);
    checkOutput("irq_set", {31'b0, irq}, 32'h1);
    busRead(STAT, 32'h1);
    busRead(4'd8, 32'h12345678);
    busRead(4'd11, 32'h44444444);
    busWrite(STAT, 32'h1, 4'h1);
    waitCycles(1);
    checkOutput("irq_clear", {31'b0, irq}, 32'h0);
    busRead(STAT, 32'h0);

    // Errors while running
    busWrite(CTRL, 32'h3, 4'hF);
    busWrite(4'd1, 32'hFFFFFFFF, 4'hF);
    busWrite(CTRL, 32'h1, 4'hF);
    waitCycles(2);
    checkOutput("start_count2", startCount, 2);
    busRead(4'd1, 32'h0);
    busRead(STAT, 32'h6);
    busWrite(STAT, 32'h4, 4'h1);
    busRead(STAT, 32'h2);
    busRead(CTRL, 32'h0);

    // Core done and done-W1C in the same cycle: done wins
    coreResult[31:0] = 32'hCAFEF00D;
    applyStimulus(1'b0, 1'b1, STAT, 32'h1, 4'h1, 1'b1, 32'h0);
    busRead(STAT, 32'h1);
    busRead(4'd8, 32'hCAFEF00D);

    // Restart from DONE clears done; then done races an overrun start
    busWrite(CTRL, 32'h1, 4'hF);
    busRead(STAT, 32'h2);
    coreResult[31:0] = 32'h0BADC0DE;
    applyStimulus(1'b0, 1'b1, CTRL, 32'h1, 4'h1, 1'b1, 32'h0);
    waitCycles(2);
    checkOutput("start_count3", startCount, 3);
    busRead(STAT, 32'h5);
    busRead(4'd8, 32'h0BADC0DE);
    busWrite(STAT, 32'h5, 4'h1);
    busRead(STAT, 32'h0);

    // Stray done in IDLE
    coreResult[31:0] = 32'hFFFF0000;
    applyStimulus(1'b0, 1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 32'h0);
    busRead(STAT, 32'h4);
    busRead(4'd8, 32'h0BADC0DE);
    busWrite(STAT, 32'h4, 4'h1);
    busRead(STAT, 32'h0);

    // Simultaneous read and write returns the old value
    busWrite(4'd2, 32'h0000AAAA, 4'hF);
    applyStimulus(1'b1, 1'b1, 4'd2, 32'h00005555, 4'hF, 1'b0, 32'h0000AAAA);
    busRead(4'd2, 32'h00005555);

    // Unmapped and result addresses ignore writes
    busWrite(4'd12, 32'hFFFFFFFF, 4'hF);
    busWrite(4'd13, 32'hFFFFFFFF, 4'hF);
    busWrite(4'd8, 32'h00000001, 4'hF);
    busRead(4'd12, 32'h0);
    busRead(4'd13, 32'h0);
    busRead(4'd8, 32'h0BADC0DE);

    // Asynchronous reset in the middle of a run
    busWrite(CTRL, 32'h3, 4'hF);
    #2 resetN = 1'b0;
    #1;
    checkOutput("midrst_start", {31'b0, coreStart}, 32'h0);
    checkOutput("midrst_readdata", avlReaddata, 32'h0);
    checkOutput("midrst_export", exportData, 32'h0);
    checkOutput("midrst_operands", {31'b0, |coreOperands}, 32'h0);
    checkOutput("midrst_irq", {31'b0, irq}, 32'h0);
    @(negedge clk); @(negedge clk);
    resetN = 1'b1;
    coreResult[31:0] = 32'h87654321;
    applyStimulus(1'b0, 1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 32'h0);
    busRead(STAT, 32'h4);
    busRead(4'd8, 32'h0);
    busRead(4'd0, 32'h0);

    waitCycles(3);
    checkOutput("sb_drain", expQ.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
